// File: rtl/regfile_sb.sv
// Multi-port integer register file with a per-register busy scoreboard for the ID stage.
// Reads are combinational with same-cycle write bypass; register 0 is hardwired to zero.
module regfile_sb #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NRD   = 2,
    parameter  int NWR   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_rdy,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_dest,
    input  logic                flush,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0]  data_r   [NREGS];
    logic [NREGS-1:0] busy_r;

    logic [NWR-1:0]   wr_en_s;
    logic             iss_en_s;
    logic             flush_s;
    logic [NREGS-1:0] wr_hit_s;
    logic [NREGS-1:0] iss_hit_s;
    logic [NREGS-1:0] busy_nxt_s;
    logic [XLEN-1:0]  wr_val_s [NREGS];

    assign busy_vec = busy_r;

    // Qualify all update sources with reset so nothing writes or bypasses while rst is low.
    always_comb begin
        wr_en_s  = {NWR{1'b0}};
        iss_en_s = 1'b0;
        flush_s  = 1'b0;
        if (rst) begin
            wr_en_s  = wr_en;
            iss_en_s = iss_valid;
            flush_s  = flush;
        end else begin
            wr_en_s  = {NWR{1'b0}};
            iss_en_s = 1'b0;
            flush_s  = 1'b0;
        end
    end

    // Resolve write ports per register; later (higher-index) ports override earlier ones.
    always_comb begin
        wr_hit_s = {NREGS{1'b0}};
        for (int r = 0; r < NREGS; r++) begin
            wr_val_s[r] = data_r[r];
        end
        for (int i = 0; i < NWR; i++) begin
            if (wr_en_s[i] && (wr_addr[i*AW +: AW] != {AW{1'b0}})) begin
                wr_hit_s[wr_addr[i*AW +: AW]] = 1'b1;
                wr_val_s[wr_addr[i*AW +: AW]] = wr_data[i*XLEN +: XLEN];
            end else begin
                wr_hit_s = wr_hit_s;
            end
        end
    end

    // Issue decode and scoreboard next state; a same-cycle issue beats a writeback.
    always_comb begin
        iss_hit_s = {NREGS{1'b0}};
        if (iss_en_s && (iss_dest != {AW{1'b0}})) begin
            iss_hit_s[iss_dest] = 1'b1;
        end else begin
            iss_hit_s = {NREGS{1'b0}};
        end
        if (flush_s) begin
            busy_nxt_s = {NREGS{1'b0}};
        end else begin
            busy_nxt_s = (busy_r & ~wr_hit_s) | iss_hit_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Register storage and scoreboard state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                data_r[r] <= {XLEN{1'b0}};
            end
            busy_r <= {NREGS{1'b0}};
        end else begin
            data_r[0] <= {XLEN{1'b0}};
            for (int r = 1; r < NREGS; r++) begin
                data_r[r] <= wr_val_s[r];
            end
            busy_r <= busy_nxt_s;
        end
    end

    // Read ports: zero register, then highest-index matching write, then stored value.
    always_comb begin
        rd_data = {(NRD*XLEN){1'b0}};
        rd_rdy  = {NRD{1'b0}};
        for (int j = 0; j < NRD; j++) begin
            if (rd_addr[j*AW +: AW] == {AW{1'b0}}) begin
                rd_data[j*XLEN +: XLEN] = {XLEN{1'b0}};
                rd_rdy[j]               = 1'b1;
            end else begin
                rd_data[j*XLEN +: XLEN] = data_r[rd_addr[j*AW +: AW]];
                rd_rdy[j]               = ~busy_r[rd_addr[j*AW +: AW]];
                for (int i = 0; i < NWR; i++) begin
                    if (wr_en_s[i] && (wr_addr[i*AW +: AW] == rd_addr[j*AW +: AW])) begin
                        rd_data[j*XLEN +: XLEN] = wr_data[i*XLEN +: XLEN];
                        rd_rdy[j]               = 1'b1;
                    end else begin
                        rd_rdy[j] = rd_rdy[j];
                    end
                end
            end
        end
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-port integer register file with an integrated scoreboard, used in the ID stage of the pipelined CPU. It supports NRD combinational read ports with same-cycle write bypass and NWR write ports with fixed priority. A per-register busy bit is set when an instruction issues with that destination and cleared when its writeback arrives, so that ID can stall on RAW hazards against long-latency producers. Register 0 is hardwired to zero.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers; power of two, at least 2
NRD, 2, number of read ports
NWR, 2, number of write ports; a higher index has higher priority
AW (localparam), $clog2(NREGS), register address width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-low reset
wr_en  in  NWR  per-port write enable
wr_addr  in  NWR*AW  write addresses; port i occupies bits [i*AW +: AW]
wr_data  in  NWR*XLEN  write data; port i occupies bits [i*XLEN +: XLEN]
rd_addr  in  NRD*AW  read addresses, packed the same way
rd_data  out  NRD*XLEN  read data, combinational
rd_rdy  out  NRD  operand valid (not pending), combinational
iss_valid  in  1  an instruction issues this cycle with a destination register
iss_dest  in  AW  destination register of the issuing instruction
flush  in  1  clear all busy bits (pipeline squash)
busy_vec  out  NREGS  registered scoreboard; bit r set means r is pending

Behaviour:
- Reset (rst==0 at a clock edge): all data entries become 0 and busy_vec becomes 0. While rst==0, wr_en, iss_valid and flush are ignored for both state and bypass.
- Register 0: writes to it are dropped and do not bypass, issues to it do not set busy, reads return 0, and its rd_rdy is always 1. busy_vec[0] is always 0.
- Write: on the clock edge, data[wr_addr[i]] <= wr_data[i] for each enabled port with a nonzero address. If several enabled ports target the same register, the highest port index wins.
- Read: rd_data[j] is selected in this order:
  - 0 if rd_addr[j]==0;
  - otherwise wr_data of the highest-index enabled port whose address equals rd_addr[j] (same-cycle bypass);
  - otherwise data[rd_addr[j]].
  - Zero cycles of latency.
- rd_rdy[j] = (rd_addr[j]==0) | ~busy_vec[rd_addr[j]] | (any enabled write port matches rd_addr[j]). A same-cycle issue to that register does not affect rd_rdy in that cycle.
- Scoreboard next state for r != 0:
  - busy[r] <= flush ? 0 : ((busy[r] & ~wr_hit[r]) | iss_hit[r]).
  - wr_hit[r] means any enabled write port addresses r. iss_hit[r] means iss_valid & (iss_dest==r).
- Simultaneous writeback and issue to the same register: busy ends set, because the newer producer wins. The write data is still stored.
- Writeback to a register that is not busy: data is stored and busy stays 0.
- Flush together with a write: the write data is stored and all busy bits are cleared. Flush together with an issue: the issue is dropped (busy stays 0).
- Each busy bit is a single bit, with no counting. ID guarantees at most one outstanding producer per register; a second issue to a busy register leaves it busy.
- No internal FSM beyond the scoreboard. All storage is flops; no RAM inference.

Test Plan:
- Reset: hold rst=0 for 2 cycles after random writes, then read all registers -> every rd_data=0, busy_vec=0, and every rd_rdy=1.
- Write/read and x0: write 0xDEADBEEF to r5, then read r5 on both ports -> 0xDEADBEEF. Write 0x1234 to r0, then read r0 -> 0, and busy_vec[0] stays 0.
- Bypass and priority: in one cycle, port0 writes r7=0xAAAA and port1 writes r7=0x5555 while rd_addr0=7 -> rd_data0=0x5555 in the same cycle. The next cycle, stored r7 reads 0x5555.
- Scoreboard:
  - Issue r3: the next cycle busy_vec[3]=1 and rd_rdy=0 for r3.
  - Writeback r3=0x42: in that cycle rd_rdy=1 and rd_data=0x42; the next cycle busy_vec[3]=0.
- Simultaneous events:
  - Writeback r9 and issue r9 in the same cycle -> busy_vec[9]=1 afterwards, and r9 reads the written data.
  - Flush with issue r4 -> busy_vec all 0 afterwards.
- Reset mid-operation: set r2 busy and hold a pending write, then assert rst=0 with wr_en=1 and iss_valid=1 -> no bypass during reset; after release, r2=0 and busy_vec=0.
